clock_step_controller: RTL and testbench
========================================

Name: clock_step_controller

Overview:
Sequences the SAP-1 CPU clock-enable from debounced front-panel button events and the CPU HLT signal.
- Operates in manual single-step, free-running auto, or halted mode.
- Sits between the two Debouncer instances (step button, mode button) and the SAP-1 core, whose registers advance only when cpu_ce is high.
- Also keeps a wrapping count of issued CPU cycles for the display.

Parameters:
DIV, 5_000_000, clk cycles between cpu_ce pulses in auto mode (10 Hz at 50 MHz); legal range 2..2^24.
CNT_W, $clog2(DIV), prescaler counter width (derived, not overridden).
CYC_W, 16, width of ce_count.

Ports:
clk  in  1  system clock; all logic on posedge.
clr  in  1  synchronous active-low reset; clr=0 sampled at posedge resets the block, clr=1 runs.
step  in  1  one-cycle pulse, debounced step-button press (Debouncer PB_down).
mode_toggle  in  1  one-cycle pulse, debounced mode-button press (Debouncer PB_down).
hlt  in  1  level from the SAP-1 control word; high means the HLT instruction has executed.
cpu_ce  out  1  one-cycle clock-enable to the CPU core, registered.
mode  out  2  current mode (clk_mode_t encoding).
ce_count  out  CYC_W  number of cpu_ce pulses issued since reset; wraps.

Behaviour:
- Reset (clr=0 at posedge): mode=MODE_MANUAL, cpu_ce=0, prescaler=0, ce_count=0. Reset overrides all inputs, including mid-pulse and in HALT.
- All outputs are registered. Decisions are made on inputs sampled at edge N; the effect is visible after edge N.
- MODE_MANUAL:
  - step=1 at edge N -> cpu_ce=1 for exactly the cycle after N.
  - Back-to-back step pulses produce back-to-back cpu_ce.
  - mode_toggle=1 -> MODE_AUTO, prescaler cleared, no cpu_ce.
- MODE_AUTO:
  - Prescaler increments each clk.
  - At prescaler==DIV-1: prescaler<=0 and cpu_ce=1 for one cycle. The first cpu_ce is the DIV-th cycle after entry; the period is exactly DIV.
  - step is ignored.
  - mode_toggle=1 -> MODE_MANUAL, prescaler cleared, no cpu_ce even on terminal count.
- MODE_HALT:
  - Entered from MANUAL or AUTO when hlt=1 is sampled.
  - cpu_ce is forced 0 in the same decision, so a step or terminal count coinciding with hlt issues no pulse.
  - step, mode_toggle and hlt are ignored. The only exit is reset.
  - The prescaler holds at 0.
- Priority per edge: clr=0 > hlt > mode_toggle > step / terminal count.
- ce_count increments on every edge where cpu_ce is driven 1 (same edge it is registered). It wraps 2^CYC_W-1 -> 0 with no flag.
- mode encoding 2'd3 is unreachable. If it is reached, the next edge forces MODE_MANUAL with cpu_ce=0.
- cpu_ce is never high for two cycles from a single event and is never high while mode=MODE_HALT.

Decomposition:
- Package sap_clk_pkg holds:
  - typedef enum logic [1:0] clk_mode_t {MODE_MANUAL=2'd0, MODE_AUTO=2'd1, MODE_HALT=2'd2};
  - localparam CYC_W_DEFAULT=16.
- One sub-module, ce_prescaler:
  - Inputs: clk, clr, en, sclr.
  - Output: tick; parameter DIV.
  - Owns the CNT_W counter and terminal-count compare.
- Top level holds the FSM, cpu_ce register and ce_count.

Test Plan (DIV=4 for simulation):
- Reset: hold clr=0 for 3 cycles with step=1, mode_toggle=1 -> mode=0, cpu_ce=0, ce_count=0 throughout; release clr -> still mode=0.
- Manual step: step pulses at cycles 10, 11, 20 -> cpu_ce high at cycles 11, 12, 21 only; ce_count=3.
- Auto run: mode_toggle at cycle 5 -> mode=1; cpu_ce at cycles 9, 13, 17, ...; step pulses during auto produce no extra pulses; after 5 pulses ce_count=5.
- Toggle vs terminal count: in auto, assert mode_toggle on the edge where prescaler==3 -> no cpu_ce, mode=0; a following step -> exactly one cpu_ce.
- Halt: in auto, assert hlt on the terminal-count edge -> cpu_ce stays 0, mode=2; then step, mode_toggle, 20 cycles -> no cpu_ce, mode=2; pulse clr=0 -> mode=0, ce_count=0.
- Wrap: force ce_count to 16'hFFFF via a sequence of 65535 manual steps, then one more step -> ce_count=0, cpu_ce pulse still issued.

Source files
------------

// File: rtl/sap_clk_pkg.sv
// Shared types and defaults for the SAP-1 clock-enable sequencer.
package sap_clk_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_HALT   = 2'd2
    } clk_mode_t;

    localparam int unsigned CYC_W_DEFAULT = 16;

endpackage

// File: rtl/clock_step_controller_if.sv
// Front-panel events and CPU-side clock-enable outputs of the step controller.
interface clock_step_controller_if
    import sap_clk_pkg::*;
#(
    parameter int unsigned CYC_W = CYC_W_DEFAULT
);
    logic             step;
    logic             mode_toggle;
    logic             hlt;
    logic             cpu_ce;
    clk_mode_t        mode;
    logic [CYC_W-1:0] ce_count;

    // master drives the panel/CPU inputs, slave is the controller
    modport master (
        output step, mode_toggle, hlt,
        input  cpu_ce, mode, ce_count
    );

    modport slave (
        input  step, mode_toggle, hlt,
        output cpu_ce, mode, ce_count
    );

endinterface

// File: rtl/ce_prescaler.sv
// Auto-mode prescaler: counts 0..DIV-1 while enabled and flags the terminal count.
module ce_prescaler #(
    parameter int unsigned DIV = 5_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic sclr,
    output logic tick
);
    localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TC   = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_q <= '0;
        end else if (sclr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == TC) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && !sclr && (cnt_q == TC);

endmodule

// File: rtl/clock_step_controller.sv
// Generates the SAP-1 cpu_ce from step/mode button events and HLT, and counts issued cycles.
module clock_step_controller
    import sap_clk_pkg::*;
#(
    parameter int unsigned DIV   = 5_000_000,
    parameter int unsigned CYC_W = CYC_W_DEFAULT
) (
    input logic                    clk,
    input logic                    clr,
    clock_step_controller_if.slave bus
);
    clk_mode_t        mode_q, mode_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic [CYC_W-1:0] ce_count_q;
    logic             presc_en, presc_sclr, tick;

    ce_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .clr  (clr),
        .en   (presc_en),
        .sclr (presc_sclr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            mode_q <= MODE_MANUAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_MANUAL: begin
                if (bus.hlt)              mode_d = MODE_HALT;
                else if (bus.mode_toggle) mode_d = MODE_AUTO;
            end
            MODE_AUTO: begin
                if (bus.hlt)              mode_d = MODE_HALT;
                else if (bus.mode_toggle) mode_d = MODE_MANUAL;
            end
            MODE_HALT:                    mode_d = MODE_HALT;
            default:                      mode_d = MODE_MANUAL;
        endcase
    end

    // hlt and mode_toggle both pre-empt a coinciding step or terminal count
    always_comb begin
        cpu_ce_d   = 1'b0;
        presc_en   = (mode_q == MODE_AUTO) && !bus.hlt && !bus.mode_toggle;
        presc_sclr = !presc_en;
        case (mode_q)
            MODE_MANUAL: cpu_ce_d = bus.step && !bus.hlt && !bus.mode_toggle;
            MODE_AUTO:   cpu_ce_d = tick;
            default:     cpu_ce_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            cpu_ce_q   <= 1'b0;
            ce_count_q <= '0;
        end else begin
            cpu_ce_q <= cpu_ce_d;
            if (cpu_ce_d) begin
                ce_count_q <= ce_count_q + CYC_W'(1);
            end
        end
    end

    assign bus.cpu_ce   = cpu_ce_q;
    assign bus.mode     = mode_q;
    assign bus.ce_count = ce_count_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Scoreboard bench for clock_step_controller against an edge-indexed reference model.
module tb_clock_step_controller;
    import sap_clk_pkg::*;

    localparam int unsigned DIV   = 4;
    localparam int unsigned CYC_W = 16;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    clock_step_controller_if #(.CYC_W(CYC_W)) bus ();

    clock_step_controller #(
        .DIV   (DIV),
        .CYC_W (CYC_W)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct packed {
        logic             ce;
        logic [1:0]       mode;
        logic [CYC_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: mode 0=manual 1=auto 2=halt; auto pulses every DIV edges after entry.
    int               m_mode   = 0;
    logic [CYC_W-1:0] m_cnt    = '0;
    int               edge_idx = 0;
    int               entry    = 0;

    function automatic bit tc_next();
        return (m_mode == 1) && (((edge_idx - entry) % DIV) == 0);
    endfunction

    task automatic drive(input logic s, input logic t, input logic h, input logic c);
        exp_t e;
        logic ce;
        @(negedge clk);
        clr             = c;
        bus.step        = s;
        bus.mode_toggle = t;
        bus.hlt         = h;
        ce = 1'b0;
        if (!c) begin
            m_mode = 0;
            m_cnt  = '0;
        end else if (m_mode == 0) begin
            if (h)      m_mode = 2;
            else if (t) begin m_mode = 1; entry = edge_idx; end
            else if (s) ce = 1'b1;
        end else if (m_mode == 1) begin
            if (h)               m_mode = 2;
            else if (t)          m_mode = 0;
            else if (tc_next())  ce = 1'b1;
        end
        if (ce) m_cnt = m_cnt + 1'b1;
        e.ce   = ce;
        e.mode = 2'(m_mode);
        e.cnt  = m_cnt;
        exp_q.push_back(e);
        edge_idx++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: outputs are registered, so one expected entry per posedge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({bus.cpu_ce, bus.mode, bus.ce_count} !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got ce=%b mode=%0d cnt=%0d, want ce=%b mode=%0d cnt=%0d",
                         $time, bus.cpu_ce, bus.mode, bus.ce_count, e.ce, e.mode, e.cnt);
            end
        end
    end

    initial begin
        int guard;
        clr             = 1'b0;
        bus.step        = 1'b0;
        bus.mode_toggle = 1'b0;
        bus.hlt         = 1'b0;

        // reset overrides step and toggle
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);

        // manual: back-to-back and isolated steps
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // auto run with steps that must be ignored
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (24) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);

        // toggle on the terminal-count edge, then a single step
        guard = 0;
        while (!tc_next() && guard < 10) begin idle(1); guard++; end
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // halt on the terminal-count edge; only reset leaves it
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        guard = 0;
        while (!tc_next() && guard < 10) begin idle(1); guard++; end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (20) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // random mix, with rare halts and resets
        repeat (3000) drive(1'(($urandom % 3) == 0), 1'(($urandom % 8) == 0),
                            1'(($urandom % 300) == 0), 1'(($urandom % 150) != 0));

        // ce_count wrap: 65535 steps reach FFFF, the next wraps to 0
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (65536) drive(1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        guard = 0;
        while (exp_q.size() > 0 && guard < 5) begin @(posedge clk); #2; guard++; end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
